// File: rtl/vga_timing_generator.sv
// 640x480@60 timing wrapper for the VGA pixel drawer: divides clk into a pixel tick,
// presents row/col to the drawer, and registers its RGB with delay-matched sync pins.
module vga_timing_generator #(
   parameter int CLK_DIV         = 2,
   parameter int H_VISIBLE       = 640,
   parameter int H_FRONT         = 16,
   parameter int H_SYNC          = 96,
   parameter int H_BACK          = 48,
   parameter int V_VISIBLE       = 480,
   parameter int V_FRONT         = 10,
   parameter int V_SYNC          = 2,
   parameter int V_BACK          = 33,
   parameter int PIPE_DELAY      = 1,
   parameter int SYNC_ACTIVE_LOW = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  in_red,
   input  logic [3:0]  in_green,
   input  logic [3:0]  in_blue,
   output logic [31:0] row,
   output logic [31:0] col,
   output logic        display_on,
   output logic        pixel_tick,
   output logic        frame_start,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int H_W     = $clog2(H_TOTAL);
   localparam int V_W     = $clog2(V_TOTAL);
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
   localparam logic [H_W-1:0]   H_VIS    = H_W'(H_VISIBLE);
   localparam logic [H_W-1:0]   HS_FIRST = H_W'(H_VISIBLE + H_FRONT);
   localparam logic [H_W-1:0]   HS_LAST  = H_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
   localparam logic [V_W-1:0]   V_VIS    = V_W'(V_VISIBLE);
   localparam logic [V_W-1:0]   VS_FIRST = V_W'(V_VISIBLE + V_FRONT);
   localparam logic [V_W-1:0]   VS_LAST  = V_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam logic             SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

   logic [DIV_W-1:0] divider;
   logic             tick_next;
   logic [H_W-1:0]   h_count;
   logic [V_W-1:0]   v_count;
   logic             in_visible;
   logic             hs_next;
   logic             vs_next;
   logic             hs_raw;
   logic             vs_raw;
   logic [2:0]       timing_bits;
   logic [2:0]       last_bits;

   assign tick_next  = (divider == DIV_LAST);
   assign in_visible = (h_count < H_VIS) && (v_count < V_VIS);
   assign hs_next    = (h_count >= HS_FIRST) && (h_count <= HS_LAST);
   assign vs_next    = (v_count >= VS_FIRST) && (v_count <= VS_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values, independent of the order the always_ff blocks are evaluated.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         divider    <= '0;
         pixel_tick <= 1'b0;
      end else begin
         pixel_tick <= tick_next;
         divider    <= tick_next ? '0 : divider + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_count <= '0;
         v_count <= '0;
      end else if (tick_next) begin
         if (h_count == H_LAST) begin
            h_count <= '0;
            v_count <= (v_count == V_LAST) ? '0 : v_count + V_W'(1);
         end else begin
            h_count <= h_count + H_W'(1);
         end
      end
   end

   // Timing registers load from the counters before they advance on the same tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         display_on  <= 1'b0;
         row         <= '0;
         col         <= '0;
         hs_raw      <= 1'b0;
         vs_raw      <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= tick_next && (h_count == '0) && (v_count == V_VIS);
         if (tick_next) begin
            display_on <= in_visible;
            col        <= in_visible ? 32'(h_count) : '0;
            row        <= in_visible ? 32'(v_count) : '0;
            hs_raw     <= hs_next;
            vs_raw     <= vs_next;
         end
      end
   end

   assign timing_bits = {display_on, hs_raw, vs_raw};

   // Extra stages cover drawer latency beyond one tick; the pin register is the final stage.
   if (PIPE_DELAY > 1) begin : g_pipe
      logic [2:0] stages [PIPE_DELAY-1];

      // NOTE: the delay stages are reset explicitly so blanking and idle sync reach the
      // pins on the very first ticks after reset, before real timing has propagated.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int k = 0; k < PIPE_DELAY - 1; k++) begin
               stages[k] <= '0;
            end
         end else if (tick_next) begin
            stages[0] <= timing_bits;
            for (int k = 1; k < PIPE_DELAY - 1; k++) begin
               stages[k] <= stages[k-1];
            end
         end
      end

      assign last_bits = stages[PIPE_DELAY-2];
   end else begin : g_direct
      assign last_bits = timing_bits;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vga_r  <= '0;
         vga_g  <= '0;
         vga_b  <= '0;
         vga_hs <= SYNC_IDLE;
         vga_vs <= SYNC_IDLE;
      end else if (tick_next) begin
         vga_r  <= last_bits[2] ? in_red   : 4'h0;
         vga_g  <= last_bits[2] ? in_green : 4'h0;
         vga_b  <= last_bits[2] ? in_blue  : 4'h0;
         vga_hs <= last_bits[1] ^ SYNC_IDLE;
         vga_vs <= last_bits[0] ^ SYNC_IDLE;
      end
   end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench for vga_timing_generator on a shrunken 15x8 raster: one instance with
// CLK_DIV=2/PIPE_DELAY=1/active-low sync, one with CLK_DIV=1/PIPE_DELAY=3/active-high sync.
module tb_vga_timing_generator;

   localparam int HV = 8, HF = 2, HS = 3, HB = 2;
   localparam int VV = 4, VF = 1, VS = 2, VB = 1;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int DIV_A = 2, PD_A = 1;
   localparam int DIV_B = 1, PD_B = 3;
   localparam bit IDLE_A = 1'b1, IDLE_B = 1'b0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, rst_b;
   logic [3:0]  red_a, grn_a, blu_a, red_b, grn_b, blu_b;
   logic [31:0] row_a, col_a, row_b, col_b;
   logic        disp_a, tick_a, fs_a, hs_a, vs_a;
   logic        disp_b, tick_b, fs_b, hs_b, vs_b;
   logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;

   vga_timing_generator #(
      .CLK_DIV(DIV_A), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .PIPE_DELAY(PD_A), .SYNC_ACTIVE_LOW(1)
   ) dut_a (
      .clk(clk), .reset(rst_a), .in_red(red_a), .in_green(grn_a), .in_blue(blu_a),
      .row(row_a), .col(col_a), .display_on(disp_a), .pixel_tick(tick_a),
      .frame_start(fs_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
      .vga_hs(hs_a), .vga_vs(vs_a)
   );

   vga_timing_generator #(
      .CLK_DIV(DIV_B), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .PIPE_DELAY(PD_B), .SYNC_ACTIVE_LOW(0)
   ) dut_b (
      .clk(clk), .reset(rst_b), .in_red(red_b), .in_green(grn_b), .in_blue(blu_b),
      .row(row_b), .col(col_b), .display_on(disp_b), .pixel_tick(tick_b),
      .frame_start(fs_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
      .vga_hs(hs_b), .vga_vs(vs_b)
   );

   int tests = 0;
   int failed = 0;
   int cur_tick = -1;
   int fs_count, fs_first, fs_last, hs_low, vs_low;

   function automatic int h_of(input int n);
      return n % HT;
   endfunction

   function automatic int v_of(input int n);
      return (n / HT) % VT;
   endfunction

   function automatic bit vis_of(input int n);
      return (h_of(n) < HV) && (v_of(n) < VV);
   endfunction

   function automatic int col_of(input int n);
      return vis_of(n) ? h_of(n) : 0;
   endfunction

   function automatic int row_of(input int n);
      return vis_of(n) ? v_of(n) : 0;
   endfunction

   function automatic bit hs_of(input int n);
      return (h_of(n) >= HV + HF) && (h_of(n) <= HV + HF + HS - 1);
   endfunction

   function automatic bit vs_of(input int n);
      return (v_of(n) >= VV + VF) && (v_of(n) <= VV + VF + VS - 1);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s (tick %0d): observed %0d, expected %0d", tag, cur_tick, obs, exp);
      end
   endtask

   task automatic check_reset(input bit sel, input bit idle);
      cur_tick = -1;
      check(sel ? "B.rst_row"  : "A.rst_row",  sel ? row_b  : row_a,  0);
      check(sel ? "B.rst_col"  : "A.rst_col",  sel ? col_b  : col_a,  0);
      check(sel ? "B.rst_disp" : "A.rst_disp", sel ? disp_b : disp_a, 0);
      check(sel ? "B.rst_tick" : "A.rst_tick", sel ? tick_b : tick_a, 0);
      check(sel ? "B.rst_fs"   : "A.rst_fs",   sel ? fs_b   : fs_a,   0);
      check(sel ? "B.rst_r"    : "A.rst_r",    sel ? r_b    : r_a,    0);
      check(sel ? "B.rst_g"    : "A.rst_g",    sel ? g_b    : g_a,    0);
      check(sel ? "B.rst_b"    : "A.rst_b",    sel ? b_b    : b_a,    0);
      check(sel ? "B.rst_hs"   : "A.rst_hs",   sel ? hs_b   : hs_a,   idle);
      check(sel ? "B.rst_vs"   : "A.rst_vs",   sel ? vs_b   : vs_a,   idle);
   endtask

   // Tick n (counted from reset release) shows pixel n on row/col and pixel n-pd on the pins.
   // The drawer model feeds the pixel pd-1 ticks behind row/col, as a pd-1 tick drawer would.
   task automatic run(input bit sel, input int nticks, input int div, input int pd,
                      input bit idle);
      int clks, m, red_val;
      bit got;
      logic [3:0] exp_r, exp_g;
      logic exp_hs, exp_vs;
      for (int n = 0; n < nticks; n++) begin
         cur_tick = n;
         clks = 0;
         got = 1'b0;
         while (!got && clks < 8) begin
            @(posedge clk);
            #1;
            clks++;
            if (sel ? fs_b : fs_a) begin
               fs_count++;
               if (fs_count == 1) fs_first = n;
               else fs_last = n;
            end
            got = sel ? tick_b : tick_a;
         end
         check(sel ? "B.tick_spacing" : "A.tick_spacing", clks, div);

         check(sel ? "B.row"  : "A.row",  sel ? row_b  : row_a,  row_of(n));
         check(sel ? "B.col"  : "A.col",  sel ? col_b  : col_a,  col_of(n));
         check(sel ? "B.disp" : "A.disp", sel ? disp_b : disp_a, vis_of(n));
         check(sel ? "B.fs"   : "A.fs",   sel ? fs_b   : fs_a,
               (h_of(n) == 0) && (v_of(n) == VV));

         if (n < pd) begin
            exp_r  = 4'h0;
            exp_g  = 4'h0;
            exp_hs = idle;
            exp_vs = idle;
         end else begin
            m      = n - pd;
            exp_r  = vis_of(m) ? 4'(col_of(m) % 16) : 4'h0;
            exp_g  = vis_of(m) ? 4'hF : 4'h0;
            exp_hs = hs_of(m) ^ idle;
            exp_vs = vs_of(m) ^ idle;
         end
         check(sel ? "B.vga_r"  : "A.vga_r",  sel ? r_b  : r_a,  exp_r);
         check(sel ? "B.vga_g"  : "A.vga_g",  sel ? g_b  : g_a,  exp_g);
         check(sel ? "B.vga_b"  : "A.vga_b",  sel ? b_b  : b_a,  exp_g);
         check(sel ? "B.vga_hs" : "A.vga_hs", sel ? hs_b : hs_a, exp_hs);
         check(sel ? "B.vga_vs" : "A.vga_vs", sel ? vs_b : vs_a, exp_vs);

         if ((sel ? hs_b : hs_a) == 1'b0) hs_low++;
         if ((sel ? vs_b : vs_a) == 1'b0) vs_low++;

         m = n - pd + 1;
         red_val = (m >= 0) ? col_of(m) % 16 : 0;
         if (sel) red_b = 4'(red_val);
         else     red_a = 4'(red_val);
      end
   endtask

   task automatic clear_stats();
      fs_count = 0;
      fs_first = -1;
      fs_last  = -1;
      hs_low   = 0;
      vs_low   = 0;
   endtask

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      red_a = 4'h0; grn_a = 4'hF; blu_a = 4'hF;
      red_b = 4'h0; grn_b = 4'hF; blu_b = 4'hF;
      clear_stats();

      repeat (3) @(posedge clk);
      #1;
      check_reset(1'b0, IDLE_A);
      check_reset(1'b1, IDLE_B);

      // Instance A: run part of the first line, then reset asynchronously mid-line.
      @(negedge clk);
      rst_a = 1'b0;
      run(1'b0, 20, DIV_A, PD_A, IDLE_A);
      #2;
      rst_a = 1'b1;
      #1;
      check_reset(1'b0, IDLE_A);
      repeat (5) begin
         @(posedge clk);
         #1;
         check_reset(1'b0, IDLE_A);
      end

      // Instance A: restart from (0,0) and run a little over two frames.
      @(negedge clk);
      rst_a = 1'b0;
      clear_stats();
      run(1'b0, 2 * HT * VT + 5, DIV_A, PD_A, IDLE_A);
      cur_tick = -1;
      check("A.fs_count", fs_count, 2);
      check("A.fs_first", fs_first, HT * VV);
      check("A.fs_period", fs_last - fs_first, HT * VT);
      check("A.hs_low_ticks", hs_low, 16 * HS);
      check("A.vs_low_ticks", vs_low, 2 * VS * HT);

      // Instance B has been held in reset throughout.
      check_reset(1'b1, IDLE_B);
      @(negedge clk);
      rst_b = 1'b0;
      clear_stats();
      run(1'b1, HT * VT + 5, DIV_B, PD_B, IDLE_B);
      cur_tick = -1;
      check("B.fs_count", fs_count, 1);
      check("B.fs_first", fs_first, HT * VV);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
